alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_pkg.sv | 59 +++++
 rtl/alu_sequencer_alu.sv | 52 +++++
 rtl/alu_sequencer.sv | 103 ++++++++++
 tb/tb_alu_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the ALU sequencer.
package alu_sequencer_pkg;

  localparam int unsigned OP_W    = 5;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned IMM_W   = 8;
  localparam int unsigned FLAG_W  = 5;
  localparam int unsigned STATE_W = 2;

  localparam logic [OP_W-1:0] OP_ADD  = 5'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 5'd1;
  localparam logic [OP_W-1:0] OP_CMP  = 5'd2;
  localparam logic [OP_W-1:0] OP_AND  = 5'd3;
  localparam logic [OP_W-1:0] OP_OR   = 5'd4;
  localparam logic [OP_W-1:0] OP_XOR  = 5'd5;
  localparam logic [OP_W-1:0] OP_NOT  = 5'd6;
  localparam logic [OP_W-1:0] OP_LSH  = 5'd7;
  localparam logic [OP_W-1:0] OP_RSH  = 5'd8;
  localparam logic [OP_W-1:0] OP_ARSH = 5'd9;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_L = 1;
  localparam int unsigned FLAG_F = 2;
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 4;

  localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] S_READ = 2'd1;
  localparam logic [STATE_W-1:0] S_EXEC = 2'd2;
  localparam logic [STATE_W-1:0] S_WB   = 2'd3;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] dest;
    logic [REG_W-1:0] src;
    logic             use_imm;
    logic [IMM_W-1:0] imm;
    logic             imm_signed;
  } req_t;

  // CMP only compares; opcodes above ARSH are NOPs.
  function automatic logic op_writes_rf(input logic [OP_W-1:0] op);
    return (op <= OP_ARSH) && (op != OP_CMP);
  endfunction

  function automatic logic [FLAG_W-1:0] psr_mask(input logic [OP_W-1:0] op);
    logic [FLAG_W-1:0] m;
    m = '0;
    if (op == OP_ADD || op == OP_SUB) begin
      m = '1;
    end else if (op == OP_CMP) begin
      m[FLAG_L] = 1'b1;
      m[FLAG_Z] = 1'b1;
      m[FLAG_N] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/alu_sequencer_alu.sv
// Combinational ALU: a is Rdest, b is Rsrc. L/Z/N compare a against b
// (unsigned less, equal, signed less); C/F come from the add or a+~b+1 subtract.
module alu_sequencer_alu
  import alu_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result_c,
  output logic [FLAG_W-1:0] flags_c
);

  localparam int unsigned SH_W = $clog2(DATA_W);

  logic [DATA_W:0]   sum_c;
  logic [DATA_W:0]   diff_c;
  logic [SH_W-1:0]   sh_c;

  always_comb begin
    sum_c    = {1'b0, a} + {1'b0, b};
    diff_c   = {1'b0, a} + {1'b0, ~b} + (DATA_W+1)'(1);
    sh_c     = b[SH_W-1:0];
    result_c = '0;
    flags_c  = '0;
    flags_c[FLAG_L] = (a < b);
    flags_c[FLAG_Z] = (a == b);
    flags_c[FLAG_N] = ($signed(a) < $signed(b));
    case (op)
      OP_ADD: begin
        result_c        = sum_c[DATA_W-1:0];
        flags_c[FLAG_C] = sum_c[DATA_W];
        flags_c[FLAG_F] = (a[DATA_W-1] == b[DATA_W-1]) && (sum_c[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB, OP_CMP: begin
        result_c        = diff_c[DATA_W-1:0];
        flags_c[FLAG_C] = diff_c[DATA_W];
        flags_c[FLAG_F] = (a[DATA_W-1] != b[DATA_W-1]) && (diff_c[DATA_W-1] != a[DATA_W-1]);
      end
      OP_AND:  result_c = a & b;
      OP_OR:   result_c = a | b;
      OP_XOR:  result_c = a ^ b;
      OP_NOT:  result_c = ~b;
      OP_LSH:  result_c = a << sh_c;
      OP_RSH:  result_c = a >> sh_c;
      OP_ARSH: result_c = DATA_W'($signed(a) >>> sh_c);
      default: result_c = '0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Four-state (IDLE/READ/EXEC/WB) sequencer issuing one register-file ALU
// operation at a time, with write-back and flag update at the end of WB.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREG   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_op,
  input  logic [3:0]        req_dest,
  input  logic [3:0]        req_src,
  input  logic              req_use_imm,
  input  logic [7:0]        req_imm,
  input  logic              req_imm_signed,
  output logic              done_valid,
  output logic [DATA_W-1:0] done_result,
  output logic [4:0]        psr,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_next;
  req_t               req_q;
  logic [DATA_W-1:0]  a_q;
  logic [DATA_W-1:0]  b_q;
  logic [FLAG_W-1:0]  flags_q;
  logic [DATA_W-1:0]  rf [NREG];
  logic [DATA_W-1:0]  imm_ext_c;
  logic [DATA_W-1:0]  alu_result_c;
  logic [FLAG_W-1:0]  alu_flags_c;
  logic               handshake_c;

  assign handshake_c = req_valid && req_ready;
  assign dbg_data    = rf[dbg_addr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (handshake_c) state_next = S_READ;
      S_READ:  state_next = S_EXEC;
      S_EXEC:  state_next = S_WB;
      S_WB:    state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    imm_ext_c = req_q.imm_signed ? {{(DATA_W-IMM_W){req_q.imm[IMM_W-1]}}, req_q.imm}
                                 : {{(DATA_W-IMM_W){1'b0}}, req_q.imm};
  end

  // done_result doubles as the registered ALU result used for write-back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      flags_q     <= '0;
      done_valid  <= 1'b0;
      done_result <= '0;
      psr         <= '0;
      req_ready   <= 1'b1;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      req_ready  <= (state_next == S_IDLE);
      done_valid <= (state == S_EXEC);
      if (handshake_c) begin
        req_q <= {req_op, req_dest, req_src, req_use_imm, req_imm, req_imm_signed};
      end
      if (state == S_READ) begin
        a_q <= rf[req_q.dest];
        b_q <= req_q.use_imm ? imm_ext_c : rf[req_q.src];
      end
      if (state == S_EXEC) begin
        done_result <= alu_result_c;
        flags_q     <= alu_flags_c;
      end
      if (state == S_WB) begin
        if (op_writes_rf(req_q.op)) rf[req_q.dest] <= done_result;
        psr <= (psr & ~psr_mask(req_q.op)) | (flags_q & psr_mask(req_q.op));
      end
    end
  end

  alu_sequencer_alu #(.DATA_W(DATA_W)) u_alu (
    .op       (req_q.op),
    .a        (a_q),
    .b        (b_q),
    .result_c (alu_result_c),
    .flags_c  (alu_flags_c)
  );

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized scoreboard bench for alu_sequencer against an integer reference model.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [3:0]  req_dest;
  logic [3:0]  req_src;
  logic        req_use_imm;
  logic [7:0]  req_imm;
  logic        req_imm_signed;
  logic        done_valid;
  logic [15:0] done_result;
  logic [4:0]  psr;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;

  alu_sequencer dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_dest(req_dest), .req_src(req_src),
    .req_use_imm(req_use_imm), .req_imm(req_imm), .req_imm_signed(req_imm_signed),
    .done_valid(done_valid), .done_result(done_result), .psr(psr),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  bit mon_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] res;
    logic [4:0]  psr;
    logic [3:0]  dest;
    logic [15:0] dval;
    int          hs;
  } exp_t;

  exp_t        q[$];
  logic [15:0] rf_m [16];
  logic [4:0]  psr_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) rf_m[i] = 16'h0;
    psr_m = 5'h0;
  endtask

  // Reference: plain integer arithmetic; flags {N,Z,F,L,C}.
  task automatic model_exec(input logic [4:0] op, input logic [3:0] dest, input logic [3:0] src,
                            input logic ui, input logic [7:0] imm, input logic sg,
                            output logic [15:0] res);
    int a, b, sa, sb, r, sh, d;
    bit c, f, wr;
    logic [4:0] mask, flags;
    a = int'(rf_m[dest]);
    if (ui) b = (sg && imm >= 8'd128) ? int'(imm) + 65280 : int'(imm);
    else    b = int'(rf_m[src]);
    sa = (a >= 32768) ? a - 65536 : a;
    sb = (b >= 32768) ? b - 65536 : b;
    sh = b % 16;
    c = 1'b0; f = 1'b0; r = 0;
    case (op)
      5'd0: begin r = a + b; c = (r > 65535); d = sa + sb; f = (d > 32767) || (d < -32768); end
      5'd1, 5'd2: begin r = a - b + 65536; c = (a >= b); d = sa - sb; f = (d > 32767) || (d < -32768); end
      5'd3: r = a & b;
      5'd4: r = a | b;
      5'd5: r = a ^ b;
      5'd6: r = 65535 - b;
      5'd7: r = a << sh;
      5'd8: r = a >> sh;
      5'd9: r = sa >>> sh;
      default: r = 0;
    endcase
    res   = 16'(r & 32'h0000FFFF);
    flags = {sa < sb, a == b, f, a < b, c};
    mask  = (op <= 5'd1) ? 5'b11111 : (op == 5'd2) ? 5'b11010 : 5'b00000;
    wr    = (op <= 5'd9) && (op != 5'd2);
    if (wr) rf_m[dest] = res;
    psr_m = (psr_m & ~mask) | (flags & mask);
  endtask

  task automatic issue(input logic [4:0] op, input logic [3:0] dest, input logic [3:0] src,
                       input logic ui, input logic [7:0] imm, input logic sg,
                       input bit commit, input bit keep, output int hs, output int waited);
    exp_t e;
    logic [15:0] r;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_dest = dest; req_src = src;
    req_use_imm = ui; req_imm = imm; req_imm_signed = sg;
    waited = 0;
    hs = -1;
    while (!req_ready) begin
      if (waited >= 20) begin
        check("ready_timeout", 32'(waited), 32'd3);
        req_valid = 1'b0;
        return;
      end
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    #1;
    hs = cyc;
    if (commit) begin
      model_exec(op, dest, src, ui, imm, sg, r);
      e.res = r; e.psr = psr_m; e.dest = dest; e.dval = rf_m[dest]; e.hs = hs;
      q.push_back(e);
    end
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || mon_busy || !req_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("idle_timeout", 32'(n), 32'd0);
    @(negedge clk);
  endtask

  task automatic check_reg(input string name, input logic [3:0] idx, input logic [15:0] exp);
    dbg_addr = idx;
    #1;
    check(name, 32'(dbg_data), 32'(exp));
  endtask

  // Monitor: pops one expectation per completion pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done_valid === 1'b1) begin
        done_cnt++;
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got pulse with result 0x%0h, expected none", done_result);
        end else begin
          mon_busy = 1'b1;
          e = q.pop_front();
          check("done_result", 32'(done_result), 32'(e.res));
          check("latency", 32'(cyc), 32'(e.hs + 2));
          @(posedge clk);
          #1;
          check("result_hold", 32'(done_result), 32'(e.res));
          check("done_single_pulse", 32'(done_valid), 32'd0);
          dbg_addr = e.dest;
          #1;
          check("rf_dest", 32'(dbg_data), 32'(e.dval));
          check("psr", 32'(psr), 32'(e.psr));
          mon_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 400000");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs1, hs2, w1, w2, start;
    logic [4:0] op;
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_dest = '0; req_src = '0;
    req_use_imm = 1'b0; req_imm = '0; req_imm_signed = 1'b0; dbg_addr = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_done_valid", 32'(done_valid), 32'd0);
    check("rst_done_result", 32'(done_result), 32'd0);
    check("rst_psr", 32'(psr), 32'd0);
    check_reg("rst_r0", 4'd0, 16'h0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);

    // ADD r1, #5 signed
    issue(5'd0, 4'd1, 4'd0, 1'b1, 8'h05, 1'b1, 1'b1, 1'b0, hs1, w1);
    wait_idle();
    check_reg("add_r1", 4'd1, 16'h0005);

    // SUB r2(0), #1 -> 0xFFFF, N and L set
    issue(5'd1, 4'd2, 4'd0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, hs1, w1);
    wait_idle();
    check_reg("sub_r2", 4'd2, 16'hFFFF);
    check("sub_psr", 32'(psr), 32'b10010);

    // CMP r1, r1 -> Z only, C/F held at 0
    issue(5'd2, 4'd1, 4'd1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, hs1, w1);
    wait_idle();
    check("cmp_psr", 32'(psr), 32'b01000);
    check_reg("cmp_r1", 4'd1, 16'h0005);

    // Back-to-back with req_valid held; second fields change after first handshake
    issue(5'd0, 4'd4, 4'd0, 1'b1, 8'hF0, 1'b1, 1'b1, 1'b1, hs1, w1);
    issue(5'd5, 4'd4, 4'd2, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, hs2, w2);
    check("b2b_spacing", 32'(hs2 - hs1), 32'd4);
    check("b2b_ready_low", 32'(w2), 32'd3);
    wait_idle();

    // Randomized operations
    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(10, 31)) : 5'($urandom_range(0, 9));
      issue(op, 4'($urandom), 4'($urandom), 1'($urandom), 8'($urandom), 1'($urandom),
            1'b1, (i < 59) ? 1'($urandom_range(0, 3) == 0) : 1'b0, hs1, w1);
    end
    wait_idle();
    for (int i = 0; i < 16; i++) check_reg("rand_rf", 4'(i), rf_m[i]);

    // NOP opcode leaves state untouched
    issue(5'h1F, 4'd7, 4'd3, 1'b0, 8'hAA, 1'b1, 1'b1, 1'b0, hs1, w1);
    wait_idle();
    for (int i = 0; i < 16; i++) check_reg("nop_rf", 4'(i), rf_m[i]);
    check("nop_psr", 32'(psr), 32'(psr_m));

    // Reset during EXEC aborts the operation
    issue(5'd0, 4'd3, 4'd0, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b0, hs1, w1);
    @(posedge clk);
    #1;
    start = done_cnt;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
    repeat (6) @(negedge clk);
    check("abort_no_done", 32'(done_cnt), 32'(start));
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_psr", 32'(psr), 32'd0);
    check_reg("abort_r3", 4'd3, 16'h0);

    // Post-reset sanity op
    issue(5'd0, 4'd6, 4'd0, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0, hs1, w1);
    wait_idle();
    check_reg("post_rst_r6", 4'd6, 16'hFF80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
